au_op_sequencer: RTL and testbench

- Multi-cycle controller that drives the team's combinational 8-bit arithmetic unit (add/sub/pass/decrement with carry-in and carry-out) through a port interface.
- Performs ADD, SUB, unsigned MUL (shift-add) and unsigned DIV (restoring), one arithmetic-unit pass per clock.
- Sits between a requester using a start/done handshake and one shared arithmetic-unit instance.

---
 rtl/au_op_sequencer.sv | 92 +++++++++
 tb/tb_au_op_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/au_op_sequencer.sv
// au_op_sequencer: start/done controller that runs ADD, SUB, shift-add MUL and restoring DIV
// through one external combinational arithmetic unit, one pass per clock.
module au_op_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic             dbz,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic [1:0]       au_s,
   output logic             au_cin,
   input  logic [WIDTH-1:0] au_data,
   input  logic             au_cout
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0]       state, opl;
   logic [WIDTH-1:0] acc, q, m, nacc, nq;
   logic [CW-1:0]    count;
   logic             ok;
   assign busy = state == RUN;
   assign done = state == DONE;
   always_comb begin
      au_a = '0;
      au_b = '0;
      au_s = 2'd0;
      au_cin = 1'b0;
      if (state == RUN)
         case (opl)
            2'd0: begin au_a = q; au_b = m; au_s = 2'd1; end
            2'd1: begin au_a = q; au_b = m; au_s = 2'd2; au_cin = 1'b1; end
            2'd2: begin au_a = acc; au_b = q[0] ? m : '0; au_s = q[0] ? 2'd1 : 2'd0; end
            default: begin au_a = {acc[WIDTH-2:0], q[WIDTH-1]}; au_b = m; au_s = 2'd2; au_cin = 1'b1; end
         endcase
   end
   // the bit shifted out of the remainder guarantees the trial subtraction succeeds
   assign ok   = au_cout | acc[WIDTH-1];
   assign nacc = opl == 2'd3 ? (ok ? au_data : au_a) : {au_cout, au_data[WIDTH-1:1]};
   assign nq   = opl == 2'd3 ? {q[WIDTH-2:0], ok} : {au_data[0], q[WIDTH-1:1]};
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         opl <= 2'd0;
         acc <= '0;
         q <= '0;
         m <= '0;
         count <= '0;
         dbz <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  opl <= op;
                  q <= opa;
                  m <= opb;
                  acc <= '0;
                  count <= op[1] ? CW'(WIDTH) : CW'(1);
                  if (op == 2'd3 && opb == '0) begin
                     state <= DONE;
                     result_lo <= '1;
                     result_hi <= opa;
                     dbz <= 1'b1;
                  end else begin
                     state <= RUN;
                     dbz <= 1'b0;
                  end
               end
            RUN: begin
               acc <= nacc;
               q <= nq;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state <= DONE;
                  result_hi <= opl[1] ? nacc : {{(WIDTH-1){1'b0}}, au_cout};
                  result_lo <= opl[1] ? nq : au_data;
               end
            end
            default: state <= IDLE;
         endcase
   end
endmodule

// File: tb/tb_au_op_sequencer.sv
// tb_au_op_sequencer: scoreboard bench with a behavioural arithmetic-unit model.
module tb_au_op_sequencer;
   logic       clk = 0, rst = 1, start = 0, busy, done, dbz, au_cin, au_cout;
   logic [1:0] op = 0, au_s;
   logic [7:0] opa = 0, opb = 0, result_hi, result_lo, au_a, au_b, au_data;
   logic [8:0] s;
   int tests = 0, fails = 0;
   typedef struct { logic [7:0] hi; logic [7:0] lo; logic z; int lat; } exp_t;
   exp_t sb[$];

   au_op_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo), .dbz(dbz),
      .au_a(au_a), .au_b(au_b), .au_s(au_s), .au_cin(au_cin), .au_data(au_data), .au_cout(au_cout));

   always #5 clk = ~clk;

   always_comb begin
      case (au_s)
         2'd0: s = {1'b0, au_a} + 9'(au_cin);
         2'd1: s = {1'b0, au_a} + {1'b0, au_b} + 9'(au_cin);
         2'd2: s = {1'b0, au_a} + {1'b0, ~au_b} + 9'(au_cin);
         default: s = {1'b0, au_a} + 9'h0FF + 9'(au_cin);
      endcase
   end
   assign au_data = s[7:0];
   assign au_cout = s[8];

   task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      case (o)
         2'd0: begin e.hi = {7'b0, 9'(a) + 9'(b) > 9'd255}; e.lo = a + b; e.z = 0; e.lat = 2; end
         2'd1: begin e.hi = {7'b0, a >= b}; e.lo = a - b; e.z = 0; e.lat = 2; end
         2'd2: begin e.hi = p[15:8]; e.lo = p[7:0]; e.z = 0; e.lat = 9; end
         default:
            if (b == 0) begin e.hi = a; e.lo = 8'hFF; e.z = 1; e.lat = 1; end
            else begin e.hi = a % b; e.lo = a / b; e.z = 0; e.lat = 9; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      start = 1; op = o; opa = a; opb = b;
      @(negedge clk);
      start = 0; op = 2'($urandom); opa = 8'($urandom); opb = 8'($urandom);
   endtask

   task automatic wait_done(input int l0, output int lat);
      lat = l0;
      while (!done && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy, done, dbz, result_hi, result_lo} !== 19'd0 || {au_a, au_b, au_s, au_cin} !== 19'd0) begin
         fails++; $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h au=%h/%h/%h/%b want all 0",
            busy, done, dbz, result_hi, result_lo, au_a, au_b, au_s, au_cin);
      end
      rst = 0;
   endtask

   task automatic test_mul_timing;
      int lat, bc;
      exp_t e;
      issue(2'd2, 8'd13, 8'd11);
      lat = 1; bc = 0;
      while (!done && lat < 40) begin bc += int'(busy); @(negedge clk); lat++; end
      e = sb.pop_front();
      tests++;
      if (lat != e.lat || bc != 8 || busy !== 0) begin
         fails++; $display("FAIL mul_timing: lat=%0d busy_cycles=%0d busy@done=%b want %0d 8 0", lat, bc, busy, e.lat);
      end
      tests++;
      if (result_hi !== e.hi || result_lo !== e.lo || dbz !== e.z) begin
         fails++; $display("FAIL mul_13x11: got %h%h dbz=%b want %h%h dbz=%b", result_hi, result_lo, dbz, e.hi, e.lo, e.z);
      end
   endtask

   task automatic test_arith;
      logic [17:0] tbl[12] = '{
         {2'd2, 8'hFF, 8'hFF}, {2'd2, 8'h00, 8'hAB}, {2'd3, 8'd200, 8'd7}, {2'd3, 8'hFF, 8'h01},
         {2'd3, 8'h80, 8'hFF}, {2'd0, 8'hF0, 8'h20}, {2'd1, 8'h05, 8'h07}, {2'd3, 8'h5A, 8'h00},
         {2'd2, 8'hA5, 8'h3C}, {2'd1, 8'h07, 8'h05}, {2'd3, 8'hFE, 8'h10}, {2'd0, 8'h7F, 8'h01}};
      int lat;
      exp_t e;
      foreach (tbl[i]) begin
         issue(tbl[i][17:16], tbl[i][15:8], tbl[i][7:0]);
         wait_done(1, lat);
         e = sb.pop_front();
         tests++;
         if (lat != e.lat || result_hi !== e.hi || result_lo !== e.lo || dbz !== e.z) begin
            fails++; $display("FAIL arith[%0d] op=%0d %h,%h: lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
               i, tbl[i][17:16], tbl[i][15:8], tbl[i][7:0], lat, result_hi, result_lo, dbz, e.lat, e.hi, e.lo, e.z);
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         issue(2'($urandom), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
         wait_done(1, lat);
         e = sb.pop_front();
         tests++;
         if (lat != e.lat || result_hi !== e.hi || result_lo !== e.lo || dbz !== e.z) begin
            fails++; $display("FAIL b2b[%0d]: lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
               i, lat, result_hi, result_lo, dbz, e.lat, e.hi, e.lo, e.z);
         end
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      exp_t e;
      issue(2'd2, 8'h9D, 8'h47);
      @(negedge clk);
      start = 1; op = 2'd3; opa = 8'h5A; opb = 8'h00;
      @(negedge clk);
      start = 0;
      wait_done(3, lat);
      e = sb.pop_front();
      tests++;
      if (lat != e.lat || result_hi !== e.hi || result_lo !== e.lo || dbz !== e.z) begin
         fails++; $display("FAIL ignore_start: lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
            lat, result_hi, result_lo, dbz, e.lat, e.hi, e.lo, e.z);
      end
   endtask

   task automatic test_mid_reset;
      int lat, seen;
      exp_t e;
      issue(2'd2, 8'hC3, 8'h5F);
      void'(sb.pop_front());
      seen = 0;
      repeat (3) begin @(negedge clk); seen += int'(done); end
      rst = 1;
      @(negedge clk);
      rst = 0;
      tests++;
      if (seen != 0 || {busy, done, dbz, result_hi, result_lo} !== 19'd0 || {au_a, au_b, au_s, au_cin} !== 19'd0) begin
         fails++; $display("FAIL mid_reset: done_seen=%0d busy=%b done=%b dbz=%b hi=%h lo=%h au_s=%h want all 0",
            seen, busy, done, dbz, result_hi, result_lo, au_s);
      end
      seen = 0;
      repeat (12) begin @(negedge clk); seen += int'(done | busy); end
      tests++;
      if (seen != 0) begin
         fails++; $display("FAIL mid_reset_idle: busy/done cycles=%0d want 0", seen);
      end
      issue(2'd3, 8'hE1, 8'h0B);
      wait_done(1, lat);
      e = sb.pop_front();
      tests++;
      if (lat != e.lat || result_hi !== e.hi || result_lo !== e.lo || dbz !== e.z) begin
         fails++; $display("FAIL after_reset: lat=%0d hi=%h lo=%h dbz=%b want lat=%0d hi=%h lo=%h dbz=%b",
            lat, result_hi, result_lo, dbz, e.lat, e.hi, e.lo, e.z);
      end
   endtask

   initial begin
      test_reset;
      test_mul_timing;
      test_arith;
      test_back_to_back;
      test_ignore_start;
      test_mid_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
